// File: rtl/enigma_pkg.sv
// Shared types, wiring tables and helpers for the Enigma rotor stack.
// Tables cover a fixed 26-letter alphabet (A=0 .. Z=25).
package enigma_pkg;

    localparam int unsigned ALPHA = 26;
    localparam int unsigned LW    = 5;

    typedef logic [LW-1:0] letter_t;
    typedef logic [1:0]    rotor_sel_t;
    typedef int unsigned   wiring_t [ALPHA];

    localparam letter_t LETTER_LAST = letter_t'(ALPHA - 1);
    localparam letter_t LETTER_LIM  = letter_t'(ALPHA);

    // Rotor I/II/III forward wirings and their inverses; identity (sel 11) needs no table.
    localparam wiring_t WIRE_I   = '{ 4, 10, 12,  5, 11,  6,  3, 16, 21, 25, 13, 19, 14,
                                     22, 24,  7, 23, 20, 18, 15,  0,  8,  1, 17,  2,  9};
    localparam wiring_t WIRE_II  = '{ 0,  9,  3, 10, 18,  8, 17, 20, 23,  1, 11,  7, 22,
                                     19, 12,  2, 16,  6, 25, 13, 15, 24,  5, 21, 14,  4};
    localparam wiring_t WIRE_III = '{ 1,  3,  5,  7,  9, 11,  2, 15, 17, 19, 23, 21, 25,
                                     13, 24,  4,  8, 22,  6,  0, 10, 12, 20, 18, 16, 14};
    localparam wiring_t INV_I    = '{20, 22, 24,  6,  0,  3,  5, 15, 21, 25,  1,  4,  2,
                                     10, 12, 19,  7, 23, 18, 11, 17,  8, 13, 16, 14,  9};
    localparam wiring_t INV_II   = '{ 0,  9, 15,  2, 25, 22, 17, 11,  5,  1,  3, 10, 14,
                                     19, 24, 20, 16,  6,  4, 13,  7, 23, 12,  8, 21, 18};
    localparam wiring_t INV_III  = '{19,  0,  6,  1, 15,  2, 18,  3, 16,  4, 20,  5, 21,
                                     13, 25,  7, 24,  8, 23,  9, 22, 11, 17, 10, 14, 12};
    localparam wiring_t REFL_B   = '{24, 17, 20,  7, 16, 18, 11,  3, 15, 23, 13,  6, 14,
                                     10, 12,  8,  4,  1,  5, 25,  2, 22, 21,  9,  0, 19};

    localparam letter_t NOTCH_I   = letter_t'(16);
    localparam letter_t NOTCH_II  = letter_t'(4);
    localparam letter_t NOTCH_III = letter_t'(21);
    localparam letter_t NOTCH_ID  = letter_t'(25);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STEP,
        S_FWD,
        S_REFL,
        S_BWD,
        S_DONE
    } state_e;

    function automatic letter_t wire_lookup(input rotor_sel_t sel, input logic inv,
                                            input letter_t idx);
        int unsigned v;
        v = 0;
        case ({inv, sel})
            3'b000:  v = WIRE_I[idx];
            3'b001:  v = WIRE_II[idx];
            3'b010:  v = WIRE_III[idx];
            3'b100:  v = INV_I[idx];
            3'b101:  v = INV_II[idx];
            3'b110:  v = INV_III[idx];
            default: v = 32'(idx);
        endcase
        return letter_t'(v);
    endfunction

    function automatic letter_t notch_of(input rotor_sel_t sel);
        case (sel)
            2'b00:   return NOTCH_I;
            2'b01:   return NOTCH_II;
            2'b10:   return NOTCH_III;
            default: return NOTCH_ID;
        endcase
    endfunction

    function automatic letter_t letter_inc(input letter_t p);
        return (p == LETTER_LAST) ? '0 : p + letter_t'(1);
    endfunction

    function automatic letter_t letter_clamp(input letter_t l);
        return (l >= LETTER_LIM) ? '0 : l;
    endfunction

    function automatic letter_t reflect(input letter_t l);
        return letter_t'(REFL_B[l]);
    endfunction

endpackage

// File: rtl/enigma_rotor_stack_if.sv
// Letter-in / letter-out valid-ready bus of the Enigma rotor stack.
interface enigma_rotor_stack_if;

    logic                in_valid;
    logic                in_ready;
    enigma_pkg::letter_t in_letter;
    logic                out_valid;
    logic                out_ready;
    enigma_pkg::letter_t out_letter;

    modport master (
        output in_valid, in_letter, out_ready,
        input  in_ready, out_valid, out_letter
    );

    modport slave (
        input  in_valid, in_letter, out_ready,
        output in_ready, out_valid, out_letter
    );

endinterface

// File: rtl/enigma_rotor_map.sv
// One rotor pass: offset by position, forward or inverse wiring lookup, remove offset.
// Purely combinational; time-shared by the stack across all FWD/BWD cycles.
module enigma_rotor_map
    import enigma_pkg::*;
(
    input  letter_t    letter_in,
    input  letter_t    pos,
    input  rotor_sel_t sel,
    input  logic       inv,
    output letter_t    letter_out_c
);

    localparam int unsigned   SW      = LW + 1;
    localparam logic [SW-1:0] ALPHA_S = SW'(ALPHA);

    logic [SW-1:0] sum_c;
    letter_t       idx_c;
    letter_t       wired_c;

    // Modular add/subtract by a single conditional correction of ALPHA.
    always_comb begin
        sum_c        = {1'b0, letter_in} + {1'b0, pos};
        idx_c        = (sum_c >= ALPHA_S) ? LW'(sum_c - ALPHA_S) : LW'(sum_c);
        wired_c      = wire_lookup(sel, inv, idx_c);
        letter_out_c = (wired_c >= pos) ? LW'({1'b0, wired_c} - {1'b0, pos})
                                        : LW'({1'b0, wired_c} + ALPHA_S - {1'b0, pos});
    end

endmodule

// File: rtl/enigma_rotor_stack.sv
// Enigma scrambler: NUM_ROTORS stepping rotors, reflector B, one letter per transaction.
// Define ENIGMA_DOUBLE_STEP_EN for the historical middle-rotor double step.
module enigma_rotor_stack
    import enigma_pkg::*;
#(
    parameter int unsigned NUM_ROTORS = 3
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [2*NUM_ROTORS-1:0]    rotor_sel,
    input  logic                       load_en,
    input  logic [LW*NUM_ROTORS-1:0]   load_pos,
    enigma_rotor_stack_if.slave        bus,
    output logic [LW*NUM_ROTORS-1:0]   pos_out
);

    localparam int unsigned    IW       = (NUM_ROTORS > 1) ? $clog2(NUM_ROTORS) : 1;
    localparam logic [IW-1:0]  IDX_LAST = IW'(NUM_ROTORS - 1);

    state_e                          state_q, state_d;
    logic [IW-1:0]                   idx_q, idx_d;
    letter_t                         cur_q, cur_d;
    letter_t                         out_letter_q, out_letter_d;
    logic                            out_valid_q, out_valid_d;
    logic [NUM_ROTORS-1:0][LW-1:0]   pos_q, pos_d;
    logic [NUM_ROTORS-1:0][1:0]      sel_q, sel_d;
    logic [NUM_ROTORS-1:0]           step_c;
    letter_t                         map_out_c;

    enigma_rotor_map u_map (
        .letter_in    (cur_q),
        .pos          (pos_q[idx_q]),
        .sel          (sel_q[idx_q]),
        .inv          (state_q == S_BWD),
        .letter_out_c (map_out_c)
    );

    // Which rotors advance this STEP cycle, judged on pre-step positions.
    always_comb begin : step_gen
`ifndef ENIGMA_DOUBLE_STEP_EN
        logic carry;
        carry = 1'b1;
`endif
        step_c    = '0;
        step_c[0] = 1'b1;
        for (int i = 1; i < int'(NUM_ROTORS); i++) begin
`ifdef ENIGMA_DOUBLE_STEP_EN
            step_c[i] = (pos_q[i-1] == notch_of(sel_q[i-1])) ||
                        ((i < int'(NUM_ROTORS) - 1) && (pos_q[i] == notch_of(sel_q[i])));
`else
            carry     = carry && (pos_q[i-1] == notch_of(sel_q[i-1]));
            step_c[i] = carry;
`endif
        end
    end

    always_comb begin : next_state
        state_d      = state_q;
        idx_d        = idx_q;
        cur_d        = cur_q;
        out_letter_d = out_letter_q;
        out_valid_d  = out_valid_q;
        pos_d        = pos_q;
        sel_d        = sel_q;
        case (state_q)
            S_IDLE: begin
                if (load_en) begin
                    for (int i = 0; i < int'(NUM_ROTORS); i++) begin
                        pos_d[i] = letter_clamp(load_pos[LW*i +: LW]);
                    end
                end else if (bus.in_valid) begin
                    cur_d   = letter_clamp(bus.in_letter);
                    sel_d   = rotor_sel;
                    state_d = S_STEP;
                end
            end
            S_STEP: begin
                for (int i = 0; i < int'(NUM_ROTORS); i++) begin
                    if (step_c[i]) begin
                        pos_d[i] = letter_inc(pos_q[i]);
                    end
                end
                idx_d   = '0;
                state_d = S_FWD;
            end
            S_FWD: begin
                cur_d = map_out_c;
                if (idx_q == IDX_LAST) begin
                    state_d = S_REFL;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            S_REFL: begin
                cur_d   = reflect(cur_q);
                idx_d   = IDX_LAST;
                state_d = S_BWD;
            end
            S_BWD: begin
                cur_d = map_out_c;
                if (idx_q == '0) begin
                    out_letter_d = map_out_c;
                    out_valid_d  = 1'b1;
                    state_d      = S_DONE;
                end else begin
                    idx_d = idx_q - IW'(1);
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            cur_q        <= '0;
            out_letter_q <= '0;
            out_valid_q  <= 1'b0;
            pos_q        <= '0;
            sel_q        <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cur_q        <= cur_d;
            out_letter_q <= out_letter_d;
            out_valid_q  <= out_valid_d;
            pos_q        <= pos_d;
            sel_q        <= sel_d;
        end
    end

    // in_ready must drop in the same cycle load_en is raised, so it is decoded here.
    assign bus.in_ready   = (state_q == S_IDLE) && !load_en;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_letter = out_letter_q;
    assign pos_out        = pos_q;

endmodule

// File: tb/tb_enigma_rotor_stack.sv
// Directed bench for enigma_rotor_stack with hand-computed expected letters and positions.
module tb_enigma_rotor_stack;
    import enigma_pkg::*;

    localparam int unsigned NR  = 3;
    localparam int unsigned LAT = 2 * NR + 2;

    logic                 clk = 1'b0;
    logic                 resetn;
    logic [2*NR-1:0]      rotor_sel;
    logic                 load_en;
    logic [LW*NR-1:0]     load_pos;
    logic [LW*NR-1:0]     pos_out;

    int err_cnt = 0;
    int chk_cnt = 0;

    enigma_rotor_stack_if bus ();

    enigma_rotor_stack #(.NUM_ROTORS(NR)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .rotor_sel (rotor_sel),
        .load_en   (load_en),
        .load_pos  (load_pos),
        .bus       (bus),
        .pos_out   (pos_out)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [LW*NR-1:0] pk(input letter_t l2, input letter_t l1, input letter_t l0);
        return {l2, l1, l0};
    endfunction

    task automatic load(input logic [LW*NR-1:0] p);
        load_en  = 1'b1;
        load_pos = p;
        @(negedge clk);
        load_en  = 1'b0;
    endtask

    // Send one letter, wait (bounded) for the result, then accept it.
    task automatic send(input letter_t l, input bit scramble, output letter_t got, output int lat);
        logic [2*NR-1:0] sel_save;
        bus.in_valid  = 1'b1;
        bus.in_letter = l;
        @(negedge clk);
        bus.in_valid = 1'b0;
        sel_save     = rotor_sel;
        if (scramble) rotor_sel = ~rotor_sel;
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check_val("out_valid_seen", 32'(bus.out_valid), 32'd1);
        got           = bus.out_letter;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        rotor_sel     = sel_save;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        letter_t     got;
        int          lat;
        letter_t     cipher [5];
        logic [LW*NR-1:0] third_pos;

        cipher = '{5'd1, 5'd3, 5'd25, 5'd6, 5'd14};  // BDZGO

        resetn        = 1'b0;
        rotor_sel     = '0;
        load_en       = 1'b0;
        load_pos      = '0;
        bus.in_valid  = 1'b0;
        bus.in_letter = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check_val("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_val("rst_out_letter", 32'(bus.out_letter), 32'd0);
        check_val("rst_pos", 32'(pos_out), 32'd0);
        resetn = 1'b1;
        @(negedge clk);

        // Rotors I-II-III, AAA: AAAAA -> BDZGO, positions end at AAF.
        rotor_sel = 6'b00_01_10;
        load(pk(0, 0, 0));
        for (int i = 0; i < 5; i++) begin
            send(5'd0, 1'b0, got, lat);
            check_val($sformatf("enc_a%0d", i), 32'(got), 32'(cipher[i]));
            check_val($sformatf("latency%0d", i), 32'(lat), 32'(LAT));
        end
        check_val("pos_aaf", 32'(pos_out), 32'(pk(0, 0, 5)));

        // Involution, with rotor_sel disturbed after each accept.
        load(pk(0, 0, 0));
        for (int i = 0; i < 5; i++) begin
            send(cipher[i], 1'b1, got, lat);
            check_val($sformatf("dec%0d", i), 32'(got), 32'd0);
        end

        // Stepping from ADU.
        load(pk(0, 3, 20));
        send(5'd0, 1'b0, got, lat);
        check_val("step_adv", 32'(pos_out), 32'(pk(0, 3, 21)));
        send(5'd0, 1'b0, got, lat);
        check_val("step_aew", 32'(pos_out), 32'(pk(0, 4, 22)));
        send(5'd0, 1'b0, got, lat);
`ifdef ENIGMA_DOUBLE_STEP_EN
        third_pos = pk(1, 5, 23);
`else
        third_pos = pk(0, 4, 23);
`endif
        check_val("step_third", 32'(pos_out), 32'(third_pos));

        // Identity rotors at ZZZ: everything wraps, output is reflector(A) = Y.
        rotor_sel = 6'b11_11_11;
        load(pk(25, 25, 25));
        send(5'd0, 1'b0, got, lat);
        check_val("wrap_letter", 32'(got), 32'd24);
        check_val("wrap_pos", 32'(pos_out), 32'd0);

        // Backpressure: hold DONE for 20 cycles with a competing in_valid.
        bus.in_valid  = 1'b1;
        bus.in_letter = 5'd0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check_val("bp_out_valid_seen", 32'(bus.out_valid), 32'd1);
        bus.in_valid  = 1'b1;
        bus.in_letter = 5'd1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_val("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check_val("bp_out_letter", 32'(bus.out_letter), 32'd24);
            check_val("bp_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check_val("bp_release_valid", 32'(bus.out_valid), 32'd0);
        check_val("bp_release_ready", 32'(bus.in_ready), 32'd1);
        check_val("bp_single_step", 32'(pos_out), 32'(pk(0, 0, 1)));

        // Out-of-range load positions and letters map to 0.
        rotor_sel = 6'b00_01_10;
        load(pk(26, 31, 7));
        check_val("load_clamp", 32'(pos_out), 32'(pk(0, 0, 7)));
        load(pk(0, 0, 0));
        send(5'd31, 1'b0, got, lat);
        check_val("letter_clamp", 32'(got), 32'd1);

        // load_en together with in_valid: load only, letter not taken.
        load_en       = 1'b1;
        load_pos      = pk(1, 2, 3);
        bus.in_valid  = 1'b1;
        bus.in_letter = 5'd4;
        #1;
        check_val("load_blocks_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        load_en      = 1'b0;
        bus.in_valid = 1'b0;
        check_val("load_wins_pos", 32'(pos_out), 32'(pk(1, 2, 3)));
        repeat (12) @(negedge clk);
        check_val("load_no_output", 32'(bus.out_valid), 32'd0);
        check_val("load_no_step", 32'(pos_out), 32'(pk(1, 2, 3)));

        // load_en mid-operation ignored; async reset in FWD aborts.
        load(pk(0, 0, 5));
        bus.in_valid  = 1'b1;
        bus.in_letter = 5'd0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        load_en      = 1'b1;
        load_pos     = pk(7, 7, 7);
        @(negedge clk);
        load_en = 1'b0;
        check_val("busy_load_ignored", 32'(pos_out), 32'(pk(0, 0, 6)));
        #2;
        resetn = 1'b0;
        #1;
        check_val("arst_out_valid", 32'(bus.out_valid), 32'd0);
        check_val("arst_pos", 32'(pos_out), 32'd0);
        check_val("arst_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        resetn = 1'b1;
        repeat (12) @(negedge clk);
        check_val("arst_no_output", 32'(bus.out_valid), 32'd0);
        check_val("arst_out_letter", 32'(bus.out_letter), 32'd0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
